// File: rtl/el2_lsu_nbload_tracker_pkg.sv
// Shared types for the non-blocking load tracker: entry state encoding and per-entry bookkeeping.
package el2_lsu_nbload_tracker_pkg;

  localparam int unsigned NBL_TAG_W   = 3;
  localparam int unsigned NBL_ENTRIES = 2 ** NBL_TAG_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PEND  = 2'd1,
    READY = 2'd2
  } el2_nbl_state_t;

  // Returned data is held beside this struct so XLEN stays a module parameter.
  typedef struct packed {
    el2_nbl_state_t state;
    logic [4:0]     rd;
    logic           wb_kill;
  } el2_nbl_entry_t;

endpackage

// File: rtl/el2_lsu_nbload_entry.sv
// One outstanding non-blocking load: state FSM plus destination, kill and returned-data flops.
module el2_lsu_nbload_entry
  import el2_lsu_nbload_tracker_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alloc_any,
  input  logic            alloc,
  input  logic [4:0]      alloc_rd,
  input  logic            inv,
  input  logic            data_hit,
  input  logic            data_error,
  input  logic [XLEN-1:0] data_in,
  input  logic            bypass,
  input  logic            grant,
  output logic            idle,
  output logic            ready,
  output logic            busy,
  output logic            err_evt,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] data
);

  el2_nbl_entry_t  ent;
  logic [XLEN-1:0] data_q;
  logic            waw;

  assign idle    = (ent.state == IDLE);
  assign ready   = (ent.state == READY) && !ent.wb_kill;
  assign busy    = !idle && !ent.wb_kill;
  assign rd      = ent.rd;
  assign data    = data_q;
  assign waw     = alloc_any && !alloc && (alloc_rd == ent.rd);
  // Invalidate beats data in the same cycle, so the error is suppressed too.
  assign err_evt = (ent.state == PEND) && data_hit && data_error && !inv && !alloc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent    <= '{state: IDLE, rd: '0, wb_kill: 1'b0};
      data_q <= '0;
    end else if (alloc) begin
      ent.state   <= PEND;
      ent.rd      <= alloc_rd;
      ent.wb_kill <= (alloc_rd == 5'd0);
    end else begin
      if (waw && !idle) ent.wb_kill <= 1'b1;
      case (ent.state)
        PEND: begin
          if (inv) begin
            ent.state <= IDLE;
          end else if (data_hit) begin
            if (data_error || bypass) begin
              ent.state <= IDLE;
            end else begin
              ent.state <= READY;
              data_q    <= data_in;
            end
          end
        end
        READY: if (ent.wb_kill || grant) ent.state <= IDLE;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/el2_lsu_nbload_tracker.sv
// Non-blocking load tracker: per-tag entries, writeback arbitration, rd scoreboard, imprecise errors.
// Optional RV_NBLOAD_BYPASS_EN forwards returning data straight to writeback when nothing is queued.
module el2_lsu_nbload_tracker
  import el2_lsu_nbload_tracker_pkg::*;
#(
  parameter int unsigned TAG_W = NBL_TAG_W,
  parameter int unsigned XLEN  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             nbl_valid_m,
  input  logic [TAG_W-1:0] nbl_tag_m,
  input  logic [4:0]       nbl_rd_m,
  input  logic             nbl_inv_r,
  input  logic [TAG_W-1:0] nbl_inv_tag_r,
  input  logic             nbl_data_valid,
  input  logic             nbl_data_error,
  input  logic [TAG_W-1:0] nbl_data_tag,
  input  logic [XLEN-1:0]  nbl_data,
  input  logic             wb_port_busy,
  output logic             nbl_wb_en,
  output logic [4:0]       nbl_wb_rd,
  output logic [XLEN-1:0]  nbl_wb_data,
  output logic [31:0]      nbl_rd_busy,
  output logic             nbl_full,
  output logic             nbl_load_error,
  output logic [TAG_W-1:0] nbl_error_tag
);

  localparam int unsigned ENTRIES = 1 << TAG_W;

  logic [ENTRIES-1:0] idle, ready, busy, err_evt, grant;
  logic [4:0]         ent_rd   [ENTRIES];
  logic [XLEN-1:0]    ent_data [ENTRIES];
  logic               grant_any, bypass_any;
  logic [TAG_W-1:0]   grant_idx;

  for (genvar i = 0; i < ENTRIES; i++) begin : g_entry
    el2_lsu_nbload_entry #(.XLEN(XLEN)) u_entry (
      .clk        (clk),
      .rst        (rst),
      .alloc_any  (nbl_valid_m),
      .alloc      (nbl_valid_m && (nbl_tag_m == TAG_W'(i))),
      .alloc_rd   (nbl_rd_m),
      .inv        (nbl_inv_r && (nbl_inv_tag_r == TAG_W'(i))),
      .data_hit   (nbl_data_valid && (nbl_data_tag == TAG_W'(i))),
      .data_error (nbl_data_error),
      .data_in    (nbl_data),
      .bypass     (bypass_any),
      .grant      (grant[i]),
      .idle       (idle[i]),
      .ready      (ready[i]),
      .busy       (busy[i]),
      .err_evt    (err_evt[i]),
      .rd         (ent_rd[i]),
      .data       (ent_data[i])
    );
  end

  always_comb begin
    grant     = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    if (!wb_port_busy) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        if (ready[i] && !grant_any) begin
          grant[i]  = 1'b1;
          grant_any = 1'b1;
          grant_idx = TAG_W'(i);
        end
      end
    end
  end

`ifdef RV_NBLOAD_BYPASS_EN
  // busy & ~ready isolates live PEND entries; any queued READY entry keeps ordering.
  assign bypass_any = nbl_data_valid && !nbl_data_error && !wb_port_busy && !(|ready) &&
                      busy[nbl_data_tag] && !ready[nbl_data_tag] &&
                      !(nbl_inv_r && (nbl_inv_tag_r == nbl_data_tag)) &&
                      !(nbl_valid_m && (nbl_tag_m == nbl_data_tag));
`else
  assign bypass_any = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nbl_wb_en      <= 1'b0;
      nbl_wb_rd      <= '0;
      nbl_wb_data    <= '0;
      nbl_load_error <= 1'b0;
      nbl_error_tag  <= '0;
    end else begin
      nbl_wb_en <= grant_any || bypass_any;
      if (bypass_any) begin
        nbl_wb_rd   <= ent_rd[nbl_data_tag];
        nbl_wb_data <= nbl_data;
      end else if (grant_any) begin
        nbl_wb_rd   <= ent_rd[grant_idx];
        nbl_wb_data <= ent_data[grant_idx];
      end
      nbl_load_error <= |err_evt;
      if (|err_evt) nbl_error_tag <= nbl_data_tag;
    end
  end

  always_comb begin
    nbl_rd_busy = '0;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      if (busy[i]) nbl_rd_busy[ent_rd[i]] = 1'b1;
    end
    nbl_rd_busy[0] = 1'b0;
  end

  assign nbl_full = &(~idle);

  a_alloc_idle: assert property (@(posedge clk) disable iff (rst) nbl_valid_m |-> idle[nbl_tag_m]);

endmodule
